// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the button conditioner: FSM encoding and debounce defaults.
package btn_conditioner_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } btn_state_e;

  localparam int DB_CYCLES_DEFAULT = 500000;
  localparam int DB_CYCLES_SIM     = 4;

endpackage

// File: rtl/btn_conditioner_debounce_channel.sv
// One input channel: 2-FF synchronizer, debounce FSM with stability counter,
// registered level plus press/release pulses and a press-toggled latch.
module debounce_channel
  import btn_conditioner_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press,
  output logic release_p,
  output logic toggle
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_s1, r_s2;
  btn_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_press, w_press_nxt;
  logic             r_release, w_release_nxt;
  logic             r_toggle, w_toggle_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_state   <= S_LOW;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_toggle  <= 1'b0;
    end else begin
      r_s1      <= raw;
      r_s2      <= r_s1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_toggle  <= w_toggle_nxt;
    end
  end

  // Counter holds the number of consecutive s2 samples at the candidate level.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_toggle_nxt  = r_toggle;
    case (r_state)
      S_LOW: begin
        if (r_s2) begin
          w_state_nxt = S_WAIT_HI;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!r_s2) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = S_HIGH;
          w_cnt_nxt    = '0;
          w_level_nxt  = 1'b1;
          w_press_nxt  = 1'b1;
          w_toggle_nxt = ~r_toggle;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!r_s2) begin
          w_state_nxt = S_WAIT_LO;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt   = '0;
        end
      end
      S_WAIT_LO: begin
        if (r_s2) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = S_LOW;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign level     = r_level;
  assign press     = r_press;
  assign release_p = r_release;
  assign toggle    = r_toggle;

endmodule

// File: rtl/btn_conditioner.sv
// Array of independent debounce channels for the raw button/switch inputs.
module btn_conditioner
  import btn_conditioner_pkg::*;
#(
  parameter int N_BTN     = 2,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_toggle
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_raw[g]),
      .level    (btn_level[g]),
      .press    (btn_press[g]),
      .release_p(btn_release[g]),
      .toggle   (btn_toggle[g])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with DB_CYCLES=4, N_BTN=2; expected values hand-derived.
module tb_btn_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_release, btn_toggle;

  int n_tests = 0;
  int n_fail  = 0;

  btn_conditioner #(.N_BTN(2), .DB_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_toggle (btn_toggle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Outputs are observed 1 time unit after each rising edge; inputs change at the same point.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] outs();
    return {btn_level, btn_press, btn_release, btn_toggle};
  endfunction

  task automatic do_reset();
    btn_raw = 2'b00;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  logic [7:0] acc;

  initial begin
    // 1: reset with inputs held high, then fresh press after release
    rst = 1'b0;
    btn_raw = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs", outs(), 8'h00);
    end
    rst = 1'b1;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc |= outs();
    end
    chk("rst_rel_early", acc, 8'h00);
    tick();
    chk("rst_rel_edge6", outs(), {2'b11, 2'b11, 2'b00, 2'b11});
    tick();
    chk("rst_rel_after", outs(), {2'b11, 2'b00, 2'b00, 2'b11});

    // 2: clean press and release on ch0
    do_reset();
    btn_raw = 2'b01;
    tick(5);
    chk("press_lat5", outs(), 8'h00);
    tick();
    chk("press_edge", outs(), {2'b01, 2'b01, 2'b00, 2'b01});
    tick();
    chk("press_pulse_end", outs(), {2'b01, 2'b00, 2'b00, 2'b01});
    tick(3);
    btn_raw = 2'b00;
    tick(5);
    chk("rel_lat5", outs(), {2'b01, 2'b00, 2'b00, 2'b01});
    tick();
    chk("rel_edge", outs(), {2'b00, 2'b00, 2'b01, 2'b01});
    tick();
    chk("rel_pulse_end", outs(), {2'b00, 2'b00, 2'b00, 2'b01});

    // 3: bounce every clock is rejected
    do_reset();
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = (i % 2 == 0) ? 2'b01 : 2'b00;
      tick();
      acc |= outs();
    end
    btn_raw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      acc |= outs();
    end
    chk("bounce", acc, 8'h00);

    // 4: 3 clocks high is short of threshold, exactly 4 is accepted
    do_reset();
    acc = '0;
    btn_raw = 2'b01;
    tick(3);
    btn_raw = 2'b00;
    for (int i = 0; i < 8; i++) begin
      tick();
      acc |= outs();
    end
    chk("thresh_3", acc, 8'h00);
    btn_raw = 2'b01;
    tick(4);
    btn_raw = 2'b00;
    tick();
    chk("thresh_4_early", outs(), 8'h00);
    tick();
    chk("thresh_4_edge", outs(), {2'b01, 2'b01, 2'b00, 2'b01});
    tick(4);
    chk("thresh_4_release", outs(), {2'b00, 2'b00, 2'b01, 2'b01});

    // 5: reset in the middle of a count gives no credit
    do_reset();
    btn_raw = 2'b01;
    tick(4);
    rst = 1'b0;
    tick();
    chk("midrst_outs", outs(), 8'h00);
    chk("midrst_state", {6'd0, dut.g_ch[0].u_ch.r_state}, 8'd0);
    rst = 1'b1;
    acc = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc |= outs();
    end
    chk("midrst_restart_early", acc, 8'h00);
    tick();
    chk("midrst_restart_edge", outs(), {2'b01, 2'b01, 2'b00, 2'b01});

    // 6: independence and toggle
    do_reset();
    btn_raw = 2'b01;
    tick();
    btn_raw = 2'b11;
    tick(4);
    chk("ind_early", outs(), 8'h00);
    tick();
    chk("ind_ch0_press", outs(), {2'b01, 2'b01, 2'b00, 2'b01});
    tick();
    chk("ind_ch1_press", outs(), {2'b11, 2'b10, 2'b00, 2'b11});
    tick();
    chk("ind_quiet", outs(), {2'b11, 2'b00, 2'b00, 2'b11});
    btn_raw = 2'b00;
    tick(6);
    chk("ind_release_both", outs(), {2'b00, 2'b00, 2'b11, 2'b11});
    tick(2);
    btn_raw = 2'b01;
    tick(6);
    chk("ind_ch0_press2", outs(), {2'b01, 2'b01, 2'b00, 2'b10});
    btn_raw = 2'b00;
    tick(8);
    chk("ind_final", outs(), {2'b00, 2'b00, 2'b00, 2'b10});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
